// File: rtl/wb_boot_loader_pkg.sv
// wb_boot_loader_pkg: loader FSM states and Wishbone select constant
package wb_boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, WB_WRITE, DONE, ERROR} state_e;
  localparam logic [3:0] SEL_FULL = 4'hF;
endpackage

// File: rtl/wb_boot_loader.sv
// wb_boot_loader: streams program words into memory over Wishbone, then releases CPU resets
module wb_boot_loader
  import wb_boot_loader_pkg::*;
#(
  parameter int          NUM_CORES   = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LEN_W       = 24,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     length_i,
  input  logic [31:0]          in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [NUM_CORES-1:0] cpu_rst_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_W-1:0]     words_o
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_e state;
  logic [LEN_W-1:0] len_q;
  logic [TW-1:0] timer;
  logic last;
  // Bus controls decode straight from state so an async reset drops cyc/stb at once
  assign in_ready_o = state == WAIT_DATA;
  assign wbm_cyc_o = state == WB_WRITE;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o = wbm_cyc_o;
  assign wbm_sel_o = wbm_cyc_o ? SEL_FULL : 4'h0;
  assign done_o = state == DONE;
  assign err_o = state == ERROR;
  assign cpu_rst_o = {NUM_CORES{state != DONE}};
  assign last = words_o + LEN_W'(1) == len_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      len_q <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      words_o <= '0;
      timer <= '0;
    end else
      case (state)
        IDLE: if (start_i) begin
          len_q <= length_i;
          wbm_adr_o <= BASE_ADDR;
          words_o <= '0;
          state <= length_i == '0 ? DONE : WAIT_DATA;
        end
        WAIT_DATA: if (in_valid_i) begin
          wbm_dat_o <= in_data_i;
          timer <= '0;
          state <= WB_WRITE;
        end
        WB_WRITE:
          if (wbm_err_i) state <= ERROR;
          else if (wbm_ack_i) begin
            words_o <= words_o + LEN_W'(1);
            wbm_adr_o <= wbm_adr_o + 32'd4;
            state <= last ? DONE : WAIT_DATA;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) state <= ERROR;
          else timer <= timer + TW'(1);
        default: state <= state;
      endcase
endmodule

// File: doc/wb_boot_loader.md
WB_BOOT_LOADER -- requirements
Module: wb_boot_loader

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2: number of CPU reset lines driven.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 SHALL have parameter LEN_W, default 24: width of the word-count field.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255: cycles to wait for ack before error.
REQ-005 Ports (name  direction  width  meaning):
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  begin load (sampled in IDLE only).
- length_i  in  LEN_W  number of 32-bit words to load.
- in_data_i  in  32  program word from upstream source.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  loader accepts a word.
- wbm_adr_o  out  32  Wishbone byte address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  byte selects.
- wbm_we_o / wbm_cyc_o / wbm_stb_o  out  1 each  Wishbone classic control.
- wbm_ack_i / wbm_err_i  in  1 each  slave response.
- cpu_rst_o  out  NUM_CORES  per-core reset hold, active-high.
- done_o  out  1  load completed.
- err_o  out  1  load aborted.
- words_o  out  LEN_W  words written so far.

Function
REQ-006 SHALL implement an FSM with states IDLE, WAIT_DATA, WB_WRITE, DONE, ERROR.
REQ-007 IDLE: start_i=1 with length_i!=0 -> latch length, address <= BASE_ADDR, words_o <= 0, go WAIT_DATA; start_i=1 with length_i=0 -> DONE.
REQ-008 WAIT_DATA: in_ready_o=1; on in_valid_i&&in_ready_o, register in_data_i into wbm_dat_o, go WB_WRITE.
REQ-009 WB_WRITE: cyc=stb=we=1, sel=4'hF from the first cycle in state; in_ready_o=0; all Wishbone outputs held stable until ack/err/timeout.
REQ-010 On wbm_ack_i in WB_WRITE: drop cyc/stb/we at that clock edge, words_o += 1, address += 4; if words_o+1 == latched length -> DONE, else -> WAIT_DATA.
REQ-011 Throughput SHALL be one word per 2 cycles with zero-wait-state slave.
REQ-012 wbm_err_i in WB_WRITE -> ERROR; simultaneous ack and err SHALL be treated as err.
REQ-013 Ack timer SHALL clear on WB_WRITE entry; ACK_TIMEOUT cycles in WB_WRITE without ack/err -> ERROR.
REQ-014 Address SHALL wrap modulo 2^32 without error.
REQ-015 start_i SHALL be ignored outside IDLE; DONE and ERROR are sticky until reset.
REQ-016 DONE: done_o=1, cpu_rst_o all 0 (cores released same cycle done_o rises), Wishbone idle.
REQ-017 ERROR: err_o=1, cpu_rst_o stays all 1, Wishbone idle, in_ready_o=0.
REQ-018 Data SHALL be written unmodified (no byte swap).

Reset
REQ-019 While wb_rst_ni=0: state IDLE, cpu_rst_o all 1, in_ready_o/cyc/stb/we/done_o/err_o=0, wbm_adr_o/wbm_dat_o/words_o=0, wbm_sel_o=0.
REQ-020 Reset asserted mid-transfer SHALL drop cyc/stb immediately (asynchronously) and abandon the load.

Structure
REQ-021 Package wb_boot_loader_pkg SHALL hold the state enum typedef and the Wishbone full-word select constant (4'hF).
REQ-022 Single module; ack timer inline, no sub-module.

Verification
REQ-023 length_i=4, zero-wait ack, words A0..A3 -> writes to 0x0,0x4,0x8,0xC with data A0..A3, done_o=1 at cycle ~8, cpu_rst_o=2'b00.
REQ-024 Slave inserts 3 wait states per ack -> adr/dat/sel stable during waits, words_o=4 at end, no dropped word.
REQ-025 Slave never acks, ACK_TIMEOUT=255 -> err_o=1 after 255 cycles in WB_WRITE, cpu_rst_o=2'b11, cyc=0.
REQ-026 ack and err asserted together on word 2 -> ERROR, words_o=1.
REQ-027 length_i=0 start -> done_o=1 next cycle, no Wishbone cycle issued.
REQ-028 wb_rst_ni pulsed low during WB_WRITE of word 3 -> cyc=0 immediately, all outputs at reset values, new start reloads from BASE_ADDR.
